// File: rtl/pipeline_hazard_unit.sv
// Execute-stage hazard/forwarding controller: operand forwarding, load-use and
// PC-write stalls/flushes, and a fixed-latency SPU occupancy FSM that holds EX.
module pipeline_hazard_unit #(
  parameter int RA_W    = 4,
  parameter int SPU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] RA1D,
  input  logic [RA_W-1:0] RA2D,
  input  logic [RA_W-1:0] RA1E,
  input  logic [RA_W-1:0] RA2E,
  input  logic [RA_W-1:0] WA3E,
  input  logic [RA_W-1:0] WA3M,
  input  logic [RA_W-1:0] WA3W,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            PCSrcD,
  input  logic            PCSrcE,
  input  logic            BranchTakenE,
  input  logic            SPUStartE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM,
  output logic            SPUBusy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [RA_W-1:0]  PC_REG   = RA_W'(15);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SPU_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam bit               LONG_OP  = (SPU_LAT > 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pcsrc_m_q, pcsrc_m_d;
  logic             pcsrc_w_q, pcsrc_w_d;

  logic ld_stall;
  logic pc_wr_pend;
  logic spu_start;
  logic hold;

  // MEM result takes priority over WB; the PC register is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra,
                                         input logic [RA_W-1:0] wa_m,
                                         input logic            we_m,
                                         input logic [RA_W-1:0] wa_w,
                                         input logic            we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (ra == wa_m) && (ra != PC_REG))
      sel = 2'b10;
    else if (we_w && (ra == wa_w) && (ra != PC_REG))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
  assign ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);

  assign ld_stall   = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_wr_pend = PCSrcD | PCSrcE | pcsrc_m_q;

  // done_q blocks a restart in the final EX cycle of an op whose SPUStartE is
  // still high; reset gating makes the hold drop asynchronously with reset.
  assign spu_start = (state_q == IDLE) & SPUStartE & ~BranchTakenE &
                     ~pcsrc_m_q & ~pcsrc_w_q & ~done_q & reset;
  assign hold      = spu_start | (state_q == BUSY);

  assign StallF  = ld_stall | pc_wr_pend | hold;
  assign StallD  = ld_stall | hold;
  assign StallE  = hold;
  assign FlushM  = hold;
  assign FlushE  = (ld_stall | BranchTakenE) & ~hold;
  assign FlushD  = (pc_wr_pend | pcsrc_w_q | BranchTakenE) & ~hold;
  assign SPUBusy = (state_q == BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    pcsrc_m_d = PCSrcE & ~StallE;
    pcsrc_w_d = pcsrc_m_q;
    case (state_q)
      IDLE: begin
        if (spu_start) begin
          if (LONG_OP) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pcsrc_m_q <= 1'b0;
      pcsrc_w_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      pcsrc_m_q <= pcsrc_m_d;
      pcsrc_w_q <= pcsrc_w_d;
    end
  end

endmodule
